speed_event_gen: RTL and testbench

//  Turns the three raw, active-low push-buttons (speed up / speed down / speed reset) into clean

---
 rtl/speed_evt_pkg.sv | 16 +
 rtl/key_debouncer.sv | 90 +++++++++
 rtl/speed_event_gen.sv | 75 +++++++
 tb/tb_speed_event_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_evt_pkg.sv
// Shared types and constants for the push-button speed event generator.
package speed_evt_pkg;

  typedef enum logic [1:0] {IDLE, FIRE, HOLD, RPT} key_state_t;

  // Listed in arbitration priority order, highest first.
  typedef enum logic [1:0] {EVT_RESET, EVT_UP, EVT_DOWN} speed_evt_t;

  localparam int SYNC_STAGES = 2;
  localparam int N_EVT       = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: 2-flop synchroniser, debouncer, press-edge FSM and auto-repeat timer.
module key_debouncer
  import speed_evt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int REPEAT_DELAY    = 13_500_000,
  parameter int REPEAT_PERIOD   = 2_700_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_i,
  input  logic key_n_i,
  output logic req_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt_q;
  logic                   db_n_q;
  logic                   synced_n;
  key_state_t             state_q;
  logic [HOLD_W-1:0]      hold_q;
  logic                   req_q;

  assign synced_n = sync_q[SYNC_STAGES-1];
  assign req_o    = req_q;

  // NOTE: sync flops reset to 1 (released) so leaving reset never looks like a press.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '1;
      db_cnt_q <= '0;
      db_n_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking everywhere here, so sync_q shifts as a real flop chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_i};
      // Any return of the synced level to the accepted level restarts the stability count.
      if (synced_n == db_n_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_n_q   <= synced_n;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (hold_q != '1) hold_q <= hold_q + HOLD_W'(1);
      unique case (state_q)
        IDLE: begin
          if (!db_n_q) begin
            state_q <= FIRE;
            req_q   <= 1'b1;
            hold_q  <= HOLD_W'(1);
          end
        end
        FIRE: state_q <= HOLD;
        HOLD: begin
          if (db_n_q) begin
            state_q <= IDLE;
          end else if (REPEAT_EN && hold_q == HOLD_W'(REPEAT_DELAY)) begin
            state_q <= RPT;
            req_q   <= 1'b1;
            hold_q  <= HOLD_W'(1);
          end
        end
        RPT: begin
          if (db_n_q) begin
            state_q <= IDLE;
          end else if (hold_q == HOLD_W'(REPEAT_PERIOD)) begin
            req_q  <= 1'b1;
            hold_q <= HOLD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/speed_event_gen.sv
// Board keys to single-cycle speed events: three debounced keys plus a priority
// arbiter with per-key pending flags so at most one event fires per cycle.
module speed_event_gen
  import speed_evt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int REPEAT_DELAY    = 13_500_000,
  parameter int REPEAT_PERIOD   = 2_700_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_speed_up_n,
  input  logic key_speed_down_n,
  input  logic key_speed_reset_n,
  output logic speed_up_event,
  output logic speed_down_event,
  output logic speed_reset_event
);

  logic [N_EVT-1:0] key_n;
  logic [N_EVT-1:0] req;
  logic [N_EVT-1:0] want;
  logic [N_EVT-1:0] grant;
  logic [N_EVT-1:0] pend_d, pend_q;
  logic [N_EVT-1:0] evt_q;

  assign key_n[EVT_RESET] = key_speed_reset_n;
  assign key_n[EVT_UP]    = key_speed_up_n;
  assign key_n[EVT_DOWN]  = key_speed_down_n;

  for (genvar i = 0; i < N_EVT; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      ((i == int'(EVT_RESET)) ? 1'b0 : REPEAT_EN)
    ) u_key (
      .clk    (clk),
      .rst_i  (reset),
      .key_n_i(key_n[i]),
      .req_o  (req[i])
    );
  end

  // A new request for an already-pending key simply ORs in, so it is merged.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    want  = req | pend_q;
    grant = '0;
    if (want[EVT_RESET])     grant[EVT_RESET] = 1'b1;
    else if (want[EVT_UP])   grant[EVT_UP]    = 1'b1;
    else if (want[EVT_DOWN]) grant[EVT_DOWN]  = 1'b1;
    pend_d = want & ~grant;
    if (grant[EVT_RESET]) begin
      pend_d[EVT_UP]   = 1'b0;
      pend_d[EVT_DOWN] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      evt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      evt_q  <= grant;
    end
  end

  assign speed_reset_event = evt_q[EVT_RESET];
  assign speed_up_event    = evt_q[EVT_UP];
  assign speed_down_event  = evt_q[EVT_DOWN];

endmodule

// File: tb/tb_speed_event_gen.sv
// Bench for speed_event_gen: directed table, hand-written reset sequence, and
// randomized key traffic against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_speed_event_gen;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam bit REN = 1'b1;
  localparam int NK  = 3;  // model key index: 0 reset, 1 up, 2 down (priority order)

  localparam logic [2:0] M_RS = 3'b100;
  localparam logic [2:0] M_UP = 3'b010;
  localparam logic [2:0] M_DN = 3'b001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_speed_up_n = 1'b1;
  logic key_speed_down_n = 1'b1;
  logic key_speed_reset_n = 1'b1;
  logic speed_up_event, speed_down_event, speed_reset_event;

  always #18.5 clk = ~clk;

  speed_event_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_EN      (REN)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .key_speed_up_n   (key_speed_up_n),
    .key_speed_down_n (key_speed_down_n),
    .key_speed_reset_n(key_speed_reset_n),
    .speed_up_event   (speed_up_event),
    .speed_down_event (speed_down_event),
    .speed_reset_event(speed_reset_event)
  );

  logic [2:0] dut_evt;
  assign dut_evt = {speed_reset_event, speed_up_event, speed_down_event};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int cyc, input logic [2:0] act,
                       input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: events{rst,up,dn} got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounced level flips once the last DB synchronised samples all disagree with it;
  // requests come at the press edge, then RD edges later, then every RP edges.
  logic [31:0] m_hist [NK];
  bit          m_db   [NK];
  int          m_press[NK];
  bit          m_req  [NK];
  bit          m_pend [NK];
  logic [2:0]  m_evt;
  int          m_edge;

  function automatic bit raw_key(input int k);
    case (k)
      0:       return key_speed_reset_n;
      1:       return key_speed_up_n;
      default: return key_speed_down_n;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_hist[k]  = '1;
      m_db[k]    = 1'b1;
      m_press[k] = -1;
      m_req[k]   = 1'b0;
      m_pend[k]  = 1'b0;
    end
    m_evt  = '0;
    m_edge = 0;
  endtask

  task automatic model_step();
    bit want [NK];
    bit nreq [NK];
    int won;
    int t;
    bit flip;
    if (reset) begin
      model_reset();
      return;
    end
    won = -1;
    for (int k = 0; k < NK; k++) want[k] = m_req[k] | m_pend[k];
    for (int k = 0; k < NK; k++) if (won < 0 && want[k]) won = k;
    for (int k = 0; k < NK; k++) m_pend[k] = want[k] && (k != won) && (won != 0);
    m_evt = (won < 0) ? 3'b000 : (M_RS >> won);
    for (int k = 0; k < NK; k++) begin
      nreq[k] = 1'b0;
      if (m_press[k] < 0) begin
        if (!m_db[k]) begin
          m_press[k] = m_edge;
          nreq[k]    = 1'b1;
        end
      end else if (m_db[k]) begin
        m_press[k] = -1;
      end else begin
        t = m_edge - m_press[k];
        if (k != 0 && REN && t >= RD && ((t - RD) % RP) == 0) nreq[k] = 1'b1;
      end
    end
    for (int k = 0; k < NK; k++) begin
      m_hist[k] = {m_hist[k][30:0], raw_key(k)};
      flip = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (m_hist[k][j] == m_db[k]) flip = 1'b0;
      if (flip) m_db[k] = !m_db[k];
      m_req[k] = nreq[k];
    end
    m_edge++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    key_speed_up_n    = 1'b1;
    key_speed_down_n  = 1'b1;
    key_speed_reset_n = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct { int start; int len; int period; int reps; } key_pat_t;
  typedef struct { int cyc; logic [2:0] mask; } exp_evt_t;
  typedef struct {
    string    name;
    key_pat_t up;
    key_pat_t dn;
    key_pat_t rs;
    int       n_cycles;
    exp_evt_t ev [6];
  } vec_t;

  localparam int N_VEC = 7;
  vec_t vecs [N_VEC];

  function automatic key_pat_t press(input int start, input int len);
    key_pat_t p;
    p = '{start, len, 1000, 1};
    return p;
  endfunction

  function automatic vec_t mk(input string name, input key_pat_t up, input key_pat_t dn,
                              input key_pat_t rs, input int n);
    vec_t v;
    v.name = name;
    v.up = up;
    v.dn = dn;
    v.rs = rs;
    v.n_cycles = n;
    for (int i = 0; i < 6; i++) v.ev[i] = '{-1, 3'b000};
    return v;
  endfunction

  function automatic bit pat_low(input key_pat_t p, input int c);
    if (c < p.start) return 1'b0;
    return ((c - p.start) / p.period < p.reps) && ((c - p.start) % p.period < p.len);
  endfunction

  function automatic logic [2:0] exp_at(input vec_t v, input int c);
    logic [2:0] m;
    m = '0;
    for (int i = 0; i < 6; i++) if (v.ev[i].cyc == c) m = m | v.ev[i].mask;
    return m;
  endfunction

  initial begin
    key_pat_t none;
    none = '{0, 0, 1, 0};

    vecs[0] = mk("single_up", press(0, 10), none, none, 20);
    vecs[0].ev[0] = '{7, M_UP};
    vecs[1] = mk("down_glitches", none, '{0, 3, 6, 5}, none, 40);
    vecs[2] = mk("up_hold_repeat", press(0, 50), none, none, 70);
    // Debounced release lags the raw release, so the repeat due at edge 50 still fires.
    vecs[2].ev[0] = '{7, M_UP};
    vecs[2].ev[1] = '{27, M_UP};
    vecs[2].ev[2] = '{35, M_UP};
    vecs[2].ev[3] = '{43, M_UP};
    vecs[2].ev[4] = '{51, M_UP};
    vecs[3] = mk("all_three", press(0, 10), press(0, 10), press(0, 10), 30);
    vecs[3].ev[0] = '{7, M_RS};
    vecs[4] = mk("down_then_up", press(1, 10), press(0, 10), none, 30);
    vecs[4].ev[0] = '{7, M_DN};
    vecs[4].ev[1] = '{8, M_UP};
    vecs[5] = mk("exact_debounce", press(0, DB), none, none, 20);
    vecs[5].ev[0] = '{7, M_UP};
    vecs[6] = mk("up_down_held", press(0, 30), press(0, 30), none, 50);
    vecs[6].ev[0] = '{7, M_UP};
    vecs[6].ev[1] = '{8, M_DN};
    vecs[6].ev[2] = '{27, M_UP};
    vecs[6].ev[3] = '{28, M_DN};
    vecs[6].ev[4] = '{35, M_UP};
    vecs[6].ev[5] = '{36, M_DN};

    model_reset();
    #1;
    check("reset_state", 0, dut_evt, 3'b000);

    for (int v = 0; v < N_VEC; v++) begin
      do_reset();
      for (int c = 0; c < vecs[v].n_cycles; c++) begin
        key_speed_up_n    = !pat_low(vecs[v].up, c);
        key_speed_down_n  = !pat_low(vecs[v].dn, c);
        key_speed_reset_n = !pat_low(vecs[v].rs, c);
        tick();
        check(vecs[v].name, c, dut_evt, exp_at(vecs[v], c));
      end
    end

    // Reset asserted while up is auto-repeating, during a cycle where its event is high.
    do_reset();
    key_speed_up_n = 1'b0;
    for (int c = 0; c <= 35; c++) begin
      tick();
      check("rpt_before_reset", c, dut_evt, (c == 7 || c == 27 || c == 35) ? M_UP : 3'b000);
    end
    #5;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_async_clear", 35, dut_evt, 3'b000);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("held_in_reset", c, dut_evt, 3'b000);
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("press_after_reset", c, dut_evt, (c == DB + 3) ? M_UP : 3'b000);
    end
    key_speed_up_n = 1'b1;

    // Randomized traffic against the reference model, with one async reset mid-run.
    begin
      int seg [NK];
      bit lvl [NK];
      do_reset();
      for (int k = 0; k < NK; k++) begin
        seg[k] = 0;
        lvl[k] = 1'b1;
      end
      for (int c = 0; c < 3000; c++) begin
        for (int k = 0; k < NK; k++) begin
          if (seg[k] == 0) begin
            lvl[k] = ($urandom_range(0, 9) < 6);
            seg[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 60);
          end
          seg[k]--;
        end
        key_speed_reset_n = lvl[0];
        key_speed_up_n    = lvl[1];
        key_speed_down_n  = lvl[2];
        if (c == 1500) begin
          #3;
          reset = 1'b1;
          model_reset();
          #1;
          check("random_async_reset", c, dut_evt, 3'b000);
          repeat (2) tick();
          reset = 1'b0;
        end
        tick();
        check("random", c, dut_evt, m_evt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
